// File: rtl/div_unit_if.sv
// Operand/result bundle between the EX stage (master) and the iterative divider (slave).
// start_i is a level request that EX holds high until it sees ready_o; result_o is valid exactly
// while ready_o is high. Dropping start_i, or raising annul_i, releases or aborts the divider.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  // Debug view of the FSM: 0=FREE 1=BY_ZERO 2=ON 3=END
  logic [1:0]            dbg_state;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbg_state
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbg_state
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// magnitudes divided unsigned and signs applied at the end. result = {remainder, quotient}.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_W-1:0]     rem, rem_n;
  logic [DATA_W-1:0]     quo, quo_n;
  logic [DATA_W-1:0]     dvs, dvs_n;
  logic                  neg_q, neg_q_n;
  logic                  neg_r, neg_r_n;
  logic [2*DATA_W-1:0]   result_q, result_n;
  logic                  ready_q, ready_n;

  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W:0]       shifted, diff;
  logic [DATA_W-1:0]     q_fix, r_fix;

  always_comb begin
    abs1    = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs2    = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    // The partial remainder stays below the divisor, so one extra bit catches the borrow.
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result_q;
    ready_n  = ready_q;

    case (state)
      FREE: begin
        result_n = '0;
        ready_n  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_n = BY_ZERO;
          end else begin
            // Operands and their signs are captured here; later changes are ignored.
            state_n = ON;
            cnt_n   = '0;
            rem_n   = '0;
            quo_n   = abs1;
            dvs_n   = abs2;
            neg_q_n = bus.signed_div_i && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_r_n = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
          end
        end
      end
      BY_ZERO: begin
        state_n  = END;
        result_n = '0;
        ready_n  = 1'b1;
      end
      ON: begin
        if (bus.annul_i) begin
          state_n  = FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt != CNT_W'(DATA_W)) begin
          if (!diff[DATA_W]) begin
            rem_n = diff[DATA_W-1:0];
            quo_n = {quo[DATA_W-2:0], 1'b1};
          end else begin
            rem_n = shifted[DATA_W-1:0];
            quo_n = {quo[DATA_W-2:0], 1'b0};
          end
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = END;
          result_n = {r_fix, q_fix};
          ready_n  = 1'b1;
        end
      end
      END: begin
        if (!bus.start_i || bus.annul_i) begin
          state_n  = FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quo      <= quo_n;
      dvs      <= dvs_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      result_q <= result_n;
      ready_q  <= ready_n;
    end
  end

  assign bus.result_o  = result_q;
  assign bus.ready_o   = ready_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed DIV/DIVU vectors, annul/reset aborts,
// and random vectors scored against an arithmetic reference model.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(W)) bus ();
  div_unit #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder follows dividend sign.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard: a rising ready_o pops an expectation; it must hold while ready_o, and zero otherwise.
  logic prev_ready = 1'b0;
  logic [63:0] cur_exp = 64'd0;
  always @(negedge clk) begin
    if (bus.ready_o === 1'b1 && prev_ready !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready_o=1 required no result pending at %0t", $time);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    if (bus.ready_o === 1'b1) check("result", bus.result_o, cur_exp);
    else                      check("idle_result_zero", bus.result_o, 64'd0);
    prev_ready = bus.ready_o;
  end

  // Starts at a negedge with FREE state; returns at a negedge back in FREE.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat);
    int n;
    exp_q.push_back(model(sgn, a, b));
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    n = 1;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    @(posedge clk);
    #1;
    check("ready_hold", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("ready_drop", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
  endtask

  task automatic directed(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hand);
    check("model_pin", model(sgn, a, b), hand);
    run_div(sgn, a, b, (b == 32'd0) ? 2 : 34);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          sgn;
    logic [31:0] a, b;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    directed(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    directed(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    directed(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD});
    directed(1'b1, -32'sd100, -32'sd7, {32'hFFFF_FFFE, 32'd14});
    directed(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    directed(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
    directed(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1});
    directed(1'b0, 32'd5, 32'd0, 64'd0);
    directed(1'b1, -32'sd5, 32'd0, 64'd0);

    // Annul after 10 cycles in ON: no result, back to FREE on the next edge.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_state", 64'(bus.dbg_state), 64'd0);
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check("annul_quiet", 64'(bus.ready_o), 64'd0);
    directed(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Reset after 5 cycles in ON: everything cleared immediately.
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd11;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", 64'(bus.ready_o), 64'd0);
    check("rst_mid_result", bus.result_o, 64'd0);
    check("rst_mid_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    directed(1'b1, 32'd12345, 32'd11, {32'd3, 32'd1122});

    for (int i = 0; i < 1000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, (b == 32'd0) ? 2 : 34);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
